branch_target_buffer: RTL and testbench

- Parametrised, tagged branch target buffer with per-entry saturating direction counters.
- Successor to the fixed 8-entry, untagged, 1-bit predictor used by the pipelined datapath.
- Sits beside the fetch stage: combinational lookup on the fetch PC, one-cycle registered update from the branch-resolution stage (EX/MEM).
- Adds two selectable index modes: bimodal, and gshare (global history XOR PC).

---
 rtl/bp_pkg.sv | 22 ++
 rtl/branch_target_buffer_if.sv | 28 ++
 rtl/btb_sat_counter.sv | 15 +
 rtl/branch_target_buffer.sv | 99 +++++++++
 tb/tb_branch_target_buffer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and the saturating-counter rule for the branch target buffer.
package bp_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_t;

  // Widest counter supported; narrower counters are zero-extended into this.
  localparam int SAT_MAX_W = 4;

  function automatic logic [SAT_MAX_W-1:0] sat_update(logic [SAT_MAX_W-1:0] cnt,
                                                      logic taken, int cnt_w);
    logic [SAT_MAX_W-1:0] max_cnt;
    max_cnt = SAT_MAX_W'((1 << cnt_w) - 1);
    if (taken) return (cnt >= max_cnt) ? max_cnt : cnt + 1'b1;
    return (cnt == '0) ? '0 : cnt - 1'b1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and resolution-side update signals of the branch target buffer.
interface branch_target_buffer_if
  import bp_pkg::*;
#(
  parameter int IDX_W = 4
);
  logic             clr;
  word_t            lookup_pc;
  logic             hit;
  logic             predict;
  word_t            target;
  logic [IDX_W-1:0] lookup_idx;
  logic             upd_en;
  word_t            upd_pc;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  word_t            upd_target;

  modport master (
    output clr, lookup_pc, upd_en, upd_pc, upd_idx, upd_taken, upd_target,
    input  hit, predict, target, lookup_idx
  );

  modport slave (
    input  clr, lookup_pc, upd_en, upd_pc, upd_idx, upd_taken, upd_target,
    output hit, predict, target, lookup_idx
  );
endinterface

// File: rtl/btb_sat_counter.sv
// Next value of a CNT_W-bit saturating direction counter after one resolved branch.
module btb_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_next
);
  logic [SAT_MAX_W-1:0] full;

  assign full     = sat_update(SAT_MAX_W'(cnt), taken, CNT_W);
  assign cnt_next = CNT_W'(full);
endmodule

// File: rtl/branch_target_buffer.sv
// Tagged branch target buffer: combinational lookup on the fetch PC, registered
// update from the resolution stage, bimodal or gshare indexing.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int MODE    = 0,
  parameter int GHR_W   = 4
) (
  input logic                   CLK,
  input logic                   RST,
  branch_target_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam bit GSHARE = (MODE == int'(BP_GSHARE));
  localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(1 << (CNT_W - 1));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            target;
    logic [CNT_W-1:0] cnt;
  } btb_entry_t;

  btb_entry_t       tbl_q [ENTRIES];
  logic [GHR_W-1:0] ghr_q;

  // Shifts consume the whole PC so the unused high/low bits need no special handling.
  function automatic logic [IDX_W-1:0] idx_of(word_t pc, logic [GHR_W-1:0] ghr);
    logic [IDX_W-1:0] pidx;
    pidx = IDX_W'(pc >> 2);
    return GSHARE ? (pidx ^ IDX_W'(ghr)) : pidx;
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(word_t pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

  logic [IDX_W-1:0] look_idx;
  btb_entry_t       look_e;

  assign look_idx       = idx_of(bus.lookup_pc, ghr_q);
  assign look_e         = tbl_q[look_idx];
  assign bus.lookup_idx = look_idx;
  assign bus.hit        = look_e.valid && (look_e.tag == tag_of(bus.lookup_pc));
  assign bus.predict    = bus.hit && (look_e.cnt >= CNT_ALLOC);
  assign bus.target     = bus.predict ? look_e.target : bus.lookup_pc + 32'd4;

  btb_entry_t       upd_e;
  btb_entry_t       upd_new;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_match;
  logic [CNT_W-1:0] cnt_next;

  assign upd_e     = tbl_q[bus.upd_idx];
  assign upd_tag   = tag_of(bus.upd_pc);
  assign upd_match = upd_e.valid && (upd_e.tag == upd_tag);

  btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .cnt      (upd_e.cnt),
    .taken    (bus.upd_taken),
    .cnt_next (cnt_next)
  );

  // A miss on a not-taken branch rewrites the entry unchanged.
  always_comb begin
    upd_new = upd_e;
    if (upd_match) begin
      upd_new.cnt = cnt_next;
      if (bus.upd_taken) upd_new.target = bus.upd_target;
    end else if (bus.upd_taken) begin
      upd_new.valid  = 1'b1;
      upd_new.tag    = upd_tag;
      upd_new.target = bus.upd_target;
      upd_new.cnt    = CNT_ALLOC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid  <= 1'b0;
        tbl_q[i].tag    <= '0;
        tbl_q[i].target <= '0;
        tbl_q[i].cnt    <= CNT_RST;
      end
      ghr_q <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
      ghr_q <= '0;
    end else if (bus.upd_en) begin
      tbl_q[bus.upd_idx] <= upd_new;
      if (GSHARE) ghr_q <= GHR_W'({ghr_q, bus.upd_taken});
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Bimodal and gshare instances driven in lockstep and checked against a behavioural table model.
module tb_branch_target_buffer;
  import bp_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  branch_target_buffer_if #(.IDX_W(4)) bi ();
  branch_target_buffer_if #(.IDX_W(4)) gs ();

  branch_target_buffer #(.ENTRIES(16), .TAG_W(8), .CNT_W(2), .MODE(0), .GHR_W(4))
    dut_bi (.CLK(CLK), .RST(RST), .bus(bi));
  branch_target_buffer #(.ENTRIES(16), .TAG_W(8), .CNT_W(2), .MODE(1), .GHR_W(4))
    dut_gs (.CLK(CLK), .RST(RST), .bus(gs));

  int checks = 0;
  int errors = 0;

  // model: index 0 = bimodal instance, 1 = gshare instance
  bit  m_valid [2][16];
  int  m_tag   [2][16];
  int  m_cnt   [2][16];
  logic [31:0] m_tgt [2][16];
  int  m_ghr   [2];

  logic        s_clr, s_upd_en, s_taken;
  logic [31:0] s_lpc, s_upc, s_utgt;

  function automatic int midx(int m, logic [31:0] pc);
    int p;
    p = int'((pc >> 2) & 32'hF);
    if (m == 1) p = p ^ m_ghr[1];
    return p;
  endfunction

  function automatic int mtag(logic [31:0] pc);
    return int'((pc >> 6) & 32'hFF);
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      if (RST) begin
        for (int i = 0; i < 16; i++) begin
          m_valid[m][i] = 0; m_tag[m][i] = 0; m_cnt[m][i] = 1; m_tgt[m][i] = 0;
        end
        m_ghr[m] = 0;
      end else if (s_clr) begin
        for (int i = 0; i < 16; i++) m_valid[m][i] = 0;
        m_ghr[m] = 0;
      end else if (s_upd_en) begin
        int i;
        i = midx(m, s_upc);
        if (m_valid[m][i] && m_tag[m][i] == mtag(s_upc)) begin
          if (s_taken) begin
            m_cnt[m][i] = (m_cnt[m][i] == 3) ? 3 : m_cnt[m][i] + 1;
            m_tgt[m][i] = s_utgt;
          end else begin
            m_cnt[m][i] = (m_cnt[m][i] == 0) ? 0 : m_cnt[m][i] - 1;
          end
        end else if (s_taken) begin
          m_valid[m][i] = 1; m_tag[m][i] = mtag(s_upc); m_tgt[m][i] = s_utgt; m_cnt[m][i] = 2;
        end
        if (m == 1) m_ghr[m] = ((m_ghr[m] << 1) | int'(s_taken)) & 15;
      end
    end
  endtask

  task automatic drive();
    bi.clr = s_clr; bi.lookup_pc = s_lpc; bi.upd_en = s_upd_en; bi.upd_pc = s_upc;
    bi.upd_taken = s_taken; bi.upd_target = s_utgt; bi.upd_idx = 4'(midx(0, s_upc));
    gs.clr = s_clr; gs.lookup_pc = s_lpc; gs.upd_en = s_upd_en; gs.upd_pc = s_upc;
    gs.upd_taken = s_taken; gs.upd_target = s_utgt; gs.upd_idx = 4'(midx(1, s_upc));
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic check_if(string nm, int m, logic hit, logic pred, logic [31:0] tgt, logic [3:0] idx);
    int  i;
    bit  eh, ep;
    i  = midx(m, s_lpc);
    eh = m_valid[m][i] && (m_tag[m][i] == mtag(s_lpc));
    ep = eh && (m_cnt[m][i] >= 2);
    chk({nm, ".hit"}, 32'(hit), 32'(eh));
    chk({nm, ".predict"}, 32'(pred), 32'(ep));
    chk({nm, ".target"}, tgt, ep ? m_tgt[m][i] : s_lpc + 32'd4);
    chk({nm, ".idx"}, 32'(idx), 32'(i));
  endtask

  task automatic cycle();
    settle();
    check_if("bi", 0, bi.hit, bi.predict, bi.target, bi.lookup_idx);
    check_if("gs", 1, gs.hit, gs.predict, gs.target, gs.lookup_idx);
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  initial begin
    s_clr = 0; s_upd_en = 0; s_taken = 0; s_lpc = 0; s_upc = 0; s_utgt = 0;
    RST = 1'b1;
    drive();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    RST = 1'b0;

    // cold lookup
    s_lpc = 32'h40;
    settle();
    chk("cold.hit", 32'(bi.hit), 32'd0);
    chk("cold.predict", 32'(bi.predict), 32'd0);
    chk("cold.target", bi.target, 32'h44);
    chk("cold.idx", 32'(bi.lookup_idx), 32'd0);
    cycle();

    // allocate while looking up the same entry: no bypass
    s_upd_en = 1; s_upc = 32'h40; s_taken = 1; s_utgt = 32'h100;
    settle();
    chk("same_cycle.hit", 32'(bi.hit), 32'd0);
    cycle();
    s_upd_en = 0;
    settle();
    chk("alloc.hit", 32'(bi.hit), 32'd1);
    chk("alloc.predict", 32'(bi.predict), 32'd1);
    chk("alloc.target", bi.target, 32'h100);
    s_lpc = 32'h1040;
    settle();
    chk("alias.hit", 32'(bi.hit), 32'd0);
    chk("alias.target", bi.target, 32'h1044);
    cycle();

    // saturation high, then decay, then no underflow
    s_lpc = 32'h40; s_upd_en = 1; s_taken = 1;
    repeat (3) cycle();
    s_taken = 0;
    cycle();
    s_upd_en = 0;
    settle();
    chk("sat_hi.predict", 32'(bi.predict), 32'd1);
    s_upd_en = 1;
    cycle();
    s_upd_en = 0;
    settle();
    chk("decay.hit", 32'(bi.hit), 32'd1);
    chk("decay.predict", 32'(bi.predict), 32'd0);
    chk("decay.target", bi.target, 32'h44);
    s_upd_en = 1;
    repeat (2) cycle();
    s_taken = 1;
    cycle();
    s_upd_en = 0;
    settle();
    chk("sat_lo.predict", 32'(bi.predict), 32'd0);
    cycle();

    // gshare history
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    s_upd_en = 1; s_upc = 32'h80; s_utgt = 32'h300;
    s_taken = 1; cycle();
    s_taken = 1; cycle();
    s_taken = 0; cycle();
    s_taken = 1; cycle();
    s_upd_en = 0; s_lpc = 32'h0;
    settle();
    chk("ghr.idx", 32'(gs.lookup_idx), 32'd13);
    s_clr = 1;
    cycle();
    s_clr = 0;
    settle();
    chk("clr.idx", 32'(gs.lookup_idx), 32'd0);
    s_lpc = 32'h80;
    settle();
    chk("clr.bi_hit", 32'(bi.hit), 32'd0);
    chk("clr.gs_hit", 32'(gs.hit), 32'd0);
    cycle();

    // clr wins over upd_en; RST wins over everything
    s_clr = 1; s_upd_en = 1; s_upc = 32'h200; s_taken = 1; s_utgt = 32'h500;
    cycle();
    s_clr = 0; s_upd_en = 0; s_lpc = 32'h200;
    settle();
    chk("prio_clr.hit", 32'(bi.hit), 32'd0);
    s_upd_en = 1;
    cycle();
    s_upc = 32'h240; RST = 1'b1;
    cycle();
    RST = 1'b0; s_upd_en = 0;
    settle();
    chk("prio_rst.hit_old", 32'(bi.hit), 32'd0);
    s_lpc = 32'h240;
    settle();
    chk("prio_rst.hit_new", 32'(bi.hit), 32'd0);
    cycle();

    // randomized traffic over a small PC window so entries collide and hit
    for (int n = 0; n < 400; n++) begin
      s_lpc    = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      s_upc    = ($urandom_range(0, 1) == 1) ? s_lpc
               : (($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      s_upd_en = 1'($urandom_range(0, 1));
      s_taken  = 1'($urandom_range(0, 1));
      s_utgt   = $urandom & 32'hFFFF_FFFC;
      s_clr    = ($urandom_range(0, 39) == 0);
      RST      = ($urandom_range(0, 99) == 0);
      cycle();
    end
    RST = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
